// File: rtl/mmio_initiator_pkg.sv
// Shared types for the MMIO initiator: command opcodes, response status
// codes and FSM states, plus a counter-width helper.
package mmio_initiator_pkg;

    typedef enum logic [1:0] {
        OP_WRITE = 2'd0,
        OP_READ  = 2'd1,
        OP_POLL  = 2'd2,
        OP_RSVD  = 2'd3
    } cmd_op_t;

    typedef enum logic [1:0] {
        ST_OK      = 2'd0,
        ST_TIMEOUT = 2'd1,
        ST_BAD_OP  = 2'd2
    } rsp_status_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR       = 3'd1,
        RD_ISSUE = 3'd2,
        RD_WAIT  = 3'd3,
        RSP      = 3'd4
    } state_t;

    // Bits needed to hold values 0..max_val inclusive (at least 1).
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/mmio_initiator_if.sv
// Command/response stream plus MMIO strobe bus of the initiator.
// master = the initiator's view, slave = the command source/responder side.
interface mmio_initiator_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 64
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [1:0]            cmd_op;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_data;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic [1:0]            rsp_status;

    logic                  mmio_wr_en;
    logic [ADDR_WIDTH-1:0] mmio_wr_addr;
    logic [DATA_WIDTH-1:0] mmio_wr_data;
    logic                  mmio_rd_en;
    logic [ADDR_WIDTH-1:0] mmio_rd_addr;
    logic [DATA_WIDTH-1:0] mmio_rd_data;

    modport master (
        input  cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready, mmio_rd_data,
        output cmd_ready, rsp_valid, rsp_data, rsp_status,
               mmio_wr_en, mmio_wr_addr, mmio_wr_data, mmio_rd_en, mmio_rd_addr
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready, mmio_rd_data,
        input  cmd_ready, rsp_valid, rsp_data, rsp_status,
               mmio_wr_en, mmio_wr_addr, mmio_wr_data, mmio_rd_en, mmio_rd_addr
    );

endinterface

// File: rtl/mmio_initiator.sv
// MMIO initiator: runs one WRITE / READ / POLL command at a time against an
// MMIO register responder and returns one response per command.
// Every output is a register; next values are computed from the next state.
module mmio_initiator
    import mmio_initiator_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 64,
    parameter int RD_LATENCY = 1,
    parameter int POLL_MAX   = 1024
) (
    input  logic              clk,
    input  logic              rst,
    mmio_initiator_if.master  bus
);

    localparam int PW = cnt_width(POLL_MAX);
    localparam int WW = cnt_width(RD_LATENCY);

    state_t                state_q, state_d;
    cmd_op_t               op_q, op_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;        // write data or poll mask
    logic [WW-1:0]         wait_q, wait_d;
    logic [PW-1:0]         poll_q, poll_d;
    logic [PW-1:0]         poll_inc;

    logic                  cmd_ready_q, cmd_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    rsp_status_t           rsp_status_q, rsp_status_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  rd_en_q, rd_en_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;

    assign poll_inc = poll_q + 1'b1;

    assign bus.cmd_ready    = cmd_ready_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_data     = rsp_data_q;
    assign bus.rsp_status   = rsp_status_q;
    assign bus.mmio_wr_en   = wr_en_q;
    assign bus.mmio_wr_addr = wr_addr_q;
    assign bus.mmio_wr_data = wr_data_q;
    assign bus.mmio_rd_en   = rd_en_q;
    assign bus.mmio_rd_addr = rd_addr_q;

    // State and output registers; reset drops every output and discards the command.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            op_q         <= OP_WRITE;
            addr_q       <= '0;
            data_q       <= '0;
            wait_q       <= '0;
            poll_q       <= '0;
            cmd_ready_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_status_q <= ST_OK;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            rd_en_q      <= 1'b0;
            rd_addr_q    <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            wait_q       <= wait_d;
            poll_q       <= poll_d;
            cmd_ready_q  <= cmd_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_status_q <= rsp_status_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            rd_en_q      <= rd_en_d;
            rd_addr_q    <= rd_addr_d;
        end
    end

    // Next state and next registered outputs; strobes default low so they pulse.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        addr_d       = addr_q;
        data_d       = data_q;
        wait_d       = wait_q;
        poll_d       = poll_q;
        cmd_ready_d  = cmd_ready_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_data_d   = rsp_data_q;
        rsp_status_d = rsp_status_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        rd_en_d      = 1'b0;
        rd_addr_d    = rd_addr_q;

        case (state_q)
            IDLE: begin
                if (bus.cmd_valid && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    op_d        = cmd_op_t'(bus.cmd_op);
                    addr_d      = bus.cmd_addr;
                    data_d      = bus.cmd_data;
                    poll_d      = '0;
                    case (cmd_op_t'(bus.cmd_op))
                        OP_WRITE: begin
                            state_d   = WR;
                            wr_en_d   = 1'b1;
                            wr_addr_d = bus.cmd_addr;
                            wr_data_d = bus.cmd_data;
                        end
                        OP_READ, OP_POLL: begin
                            state_d   = RD_ISSUE;
                            rd_en_d   = 1'b1;
                            rd_addr_d = bus.cmd_addr;
                        end
                        default: begin
                            state_d      = RSP;
                            rsp_valid_d  = 1'b1;
                            rsp_data_d   = '0;
                            rsp_status_d = ST_BAD_OP;
                        end
                    endcase
                end else begin
                    // First edge after reset release raises ready; stays high while idle.
                    cmd_ready_d = 1'b1;
                end
            end

            WR: begin
                state_d      = RSP;
                rsp_valid_d  = 1'b1;
                rsp_data_d   = '0;
                rsp_status_d = ST_OK;
            end

            RD_ISSUE: begin
                wait_d  = WW'(RD_LATENCY);
                state_d = RD_WAIT;
            end

            RD_WAIT: begin
                wait_d = wait_q - 1'b1;
                // Count of 1 means rd_data is valid this cycle.
                if (wait_q == WW'(1)) begin
                    rsp_data_d = bus.mmio_rd_data;
                    if (op_q == OP_READ || (bus.mmio_rd_data & data_q) != '0) begin
                        state_d      = RSP;
                        rsp_valid_d  = 1'b1;
                        rsp_status_d = ST_OK;
                    end else if (poll_inc == PW'(POLL_MAX)) begin
                        state_d      = RSP;
                        rsp_valid_d  = 1'b1;
                        rsp_status_d = ST_TIMEOUT;
                    end else begin
                        poll_d  = poll_inc;
                        state_d = RD_ISSUE;
                        rd_en_d = 1'b1;
                    end
                end
            end

            RSP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mmio_initiator.sv
// Directed bench for mmio_initiator: table of commands with hand-computed
// responses/latencies plus hand sequences for response stall and mid-command reset.
module tb_mmio_initiator;
    import mmio_initiator_pkg::*;

    localparam int AW = 16;
    localparam int DW = 64;
    localparam int RL = 1;
    localparam int PM = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mmio_initiator_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

    mmio_initiator #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(RL), .POLL_MAX(PM)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Register-map responder: 256-entry memory, 0x0060 is a done flag that
    // reads 1 from the done_after-th read of the current poll onward.
    logic [DW-1:0] mem [0:255];
    logic [DW-1:0] rd_data_q;
    logic [AW-1:0] last_wr_addr;
    logic [DW-1:0] last_wr_data;
    int wr_pulses = 0, rd_pulses = 0, overlap = 0;
    int done_base = 0, done_after = 0;

    assign bus.mmio_rd_data = rd_data_q;

    always @(posedge clk) begin
        if (bus.mmio_wr_en && bus.mmio_rd_en) overlap++;
        if (bus.mmio_wr_en) begin
            wr_pulses++;
            mem[bus.mmio_wr_addr[7:0]] <= bus.mmio_wr_data;
            last_wr_addr <= bus.mmio_wr_addr;
            last_wr_data <= bus.mmio_wr_data;
        end
        if (bus.mmio_rd_en) begin
            rd_pulses++;
            if (bus.mmio_rd_addr == 16'h0060)
                rd_data_q <= (done_after != 0 && (rd_pulses - done_base) >= done_after) ? 64'd1 : 64'd0;
            else
                rd_data_q <= mem[bus.mmio_rd_addr[7:0]];
        end
    end

    int checks = 0, failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one command, wait for its response, then complete the handshake.
    // lat / first_wr / first_rd are counted in cycles after the accept edge (1 = T+1).
    task automatic run_cmd(input logic [1:0] op, input logic [15:0] addr, input logic [63:0] data,
                           output logic [63:0] rdata, output logic [1:0] st,
                           output int lat, output int first_wr, output int first_rd);
        int k;
        lat = -1; first_wr = -1; first_rd = -1; rdata = '0; st = '0;
        @(negedge clk);
        k = 0;
        while (!bus.cmd_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("cmd_ready_before_issue", bus.cmd_ready, 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_addr  = addr;
        bus.cmd_data  = data;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        for (int n = 1; n <= 60; n++) begin
            if (bus.mmio_wr_en && first_wr < 0) first_wr = n;
            if (bus.mmio_rd_en && first_rd < 0) first_rd = n;
            if (bus.rsp_valid) begin
                lat = n; rdata = bus.rsp_data; st = bus.rsp_status;
                break;
            end
            @(negedge clk);
        end
        if (lat > 0) begin
            bus.rsp_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            bus.rsp_ready = 1'b0;
        end
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [15:0] addr;
        logic [63:0] data;
        int          done_after;
        logic [63:0] exp_data;
        logic [1:0]  exp_st;
        int          exp_lat;
        int          exp_wr;
        int          exp_rd;
    } vec_t;

    vec_t vecs [9];

    initial begin
        logic [63:0] rdata;
        logic [1:0]  st;
        int lat, fw, fr, w0, r0, bad_v, bad_d, bad_s, bad_r;

        //            op  addr      data                   done  exp_data               st  lat wr rd
        vecs[0] = '{2'd0, 16'h0056, 64'd100,               0, 64'd0,                 2'd0, 2,  1, 0};
        vecs[1] = '{2'd1, 16'h0056, 64'd0,                 0, 64'd100,               2'd0, 3,  0, 1};
        vecs[2] = '{2'd0, 16'h0010, 64'hDEADBEEF01234567,  0, 64'd0,                 2'd0, 2,  1, 0};
        vecs[3] = '{2'd1, 16'h0010, 64'd0,                 0, 64'hDEADBEEF01234567,  2'd0, 3,  0, 1};
        vecs[4] = '{2'd2, 16'h0060, 64'd1,                 5, 64'd1,                 2'd0, 11, 0, 5};
        vecs[5] = '{2'd2, 16'h0060, 64'd1,                 0, 64'd0,                 2'd1, 17, 0, 8};
        vecs[6] = '{2'd2, 16'h0060, 64'd0,                 1, 64'd1,                 2'd1, 17, 0, 8};
        vecs[7] = '{2'd2, 16'h0056, 64'd4,                 0, 64'd100,               2'd0, 3,  0, 1};
        vecs[8] = '{2'd3, 16'h0056, 64'd7,                 0, 64'd0,                 2'd2, 1,  0, 0};

        bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_addr = '0; bus.cmd_data = '0;
        bus.rsp_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", bus.cmd_ready, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_data", bus.rsp_data, 0);
        check("rst_rsp_status", bus.rsp_status, 0);
        check("rst_wr_en", bus.mmio_wr_en, 0);
        check("rst_rd_en", bus.mmio_rd_en, 0);
        check("rst_wr_addr", bus.mmio_wr_addr, 0);
        check("rst_rd_addr", bus.mmio_rd_addr, 0);
        rst = 1'b0;
        #1 check("release_cmd_ready_low", bus.cmd_ready, 0);
        bus.rsp_ready = 1'b1;  // held high while idle: no effect
        @(negedge clk);
        check("release_cmd_ready_high", bus.cmd_ready, 1);
        repeat (3) @(negedge clk);
        check("idle_rsp_ready_no_rsp", bus.rsp_valid, 0);
        bus.rsp_ready = 1'b0;

        // Table-driven commands
        for (int i = 0; i < 9; i++) begin
            done_after = vecs[i].done_after;
            done_base  = rd_pulses;
            w0 = wr_pulses; r0 = rd_pulses;
            run_cmd(vecs[i].op, vecs[i].addr, vecs[i].data, rdata, st, lat, fw, fr);
            check($sformatf("v%0d_rsp_data", i), rdata, vecs[i].exp_data);
            check($sformatf("v%0d_rsp_status", i), st, vecs[i].exp_st);
            check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
            check($sformatf("v%0d_wr_pulses", i), wr_pulses - w0, vecs[i].exp_wr);
            check($sformatf("v%0d_rd_pulses", i), rd_pulses - r0, vecs[i].exp_rd);
            check($sformatf("v%0d_first_wr", i), fw, (vecs[i].exp_wr > 0) ? 1 : -1);
            check($sformatf("v%0d_first_rd", i), fr, (vecs[i].exp_rd > 0) ? 1 : -1);
            if (vecs[i].exp_wr > 0) begin
                check($sformatf("v%0d_wr_addr", i), last_wr_addr, vecs[i].addr);
                check($sformatf("v%0d_wr_data", i), last_wr_data, vecs[i].data);
            end
            check($sformatf("v%0d_post_rsp_valid", i), bus.rsp_valid, 0);
            check($sformatf("v%0d_post_cmd_ready", i), bus.cmd_ready, 1);
        end

        // BAD_OP response held under back-pressure; a pending command is ignored
        w0 = wr_pulses; r0 = rd_pulses;
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_op = 2'd3; bus.cmd_addr = 16'h0030; bus.cmd_data = 64'd9;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_op = 2'd0; bus.cmd_addr = 16'h0077; bus.cmd_data = 64'd5;
        bad_v = 0; bad_d = 0; bad_s = 0; bad_r = 0;
        for (int n = 0; n < 10; n++) begin
            if (bus.rsp_valid !== 1'b1) bad_v++;
            if (bus.rsp_data !== 64'd0) bad_d++;
            if (bus.rsp_status !== 2'd2) bad_s++;
            if (bus.cmd_ready !== 1'b0) bad_r++;
            @(negedge clk);
        end
        check("stall_rsp_valid_drops", bad_v, 0);
        check("stall_rsp_data_changes", bad_d, 0);
        check("stall_status_changes", bad_s, 0);
        check("stall_cmd_ready_rises", bad_r, 0);
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check("stall_post_rsp_valid", bus.rsp_valid, 0);
        check("stall_post_cmd_ready", bus.cmd_ready, 1);
        check("stall_wr_pulses", wr_pulses - w0, 0);
        check("stall_rd_pulses", rd_pulses - r0, 0);

        // Reset mid-POLL while rd_en is high: everything drops at once
        done_after = 0; done_base = rd_pulses;
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_op = 2'd2; bus.cmd_addr = 16'h0060; bus.cmd_data = 64'd1;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        fr = 0;
        for (int n = 0; n < 20; n++) begin
            if (bus.mmio_rd_en) fr++;
            if (fr == 3) break;
            @(negedge clk);
        end
        check("midrst_reached_third_read", fr, 3);
        #2 rst = 1'b1;
        #1;
        check("midrst_rd_en", bus.mmio_rd_en, 0);
        check("midrst_rsp_valid", bus.rsp_valid, 0);
        check("midrst_cmd_ready", bus.cmd_ready, 0);
        r0 = rd_pulses;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_no_stale_rsp", bus.rsp_valid, 0);
        w0 = wr_pulses;
        run_cmd(2'd0, 16'h0056, 64'd100, rdata, st, lat, fw, fr);
        check("midrst_wr_latency", lat, 2);
        check("midrst_wr_status", st, 0);
        check("midrst_wr_pulses", wr_pulses - w0, 1);
        check("midrst_no_more_reads", rd_pulses - r0, 0);

        check("no_wr_rd_overlap", overlap, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
